udma_lin_tx_arbiter: RTL and testbench



---
 rtl/udma_lin_tx_arbiter_pkg.sv | 23 ++
 rtl/udma_lin_tx_arbiter_if.sv | 36 +++
 rtl/udma_lin_tx_arbiter_id_fifo.sv | 69 ++++++
 rtl/udma_lin_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_udma_lin_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udma_lin_tx_arbiter_pkg.sv
// Shared definitions for the uDMA linear TX arbiter slice.
// Holds the channel count, the outstanding-read depth, the channel ID type
// and the arbitration FSM state encoding used by udma_lin_tx_arbiter.
package udma_lin_tx_arbiter_pkg;

  // Number of TX linear channels sharing the L2 read port
  // (UART, QSPIM data/cmd, I2C data/cmd, HyperBus, ...).
  localparam int N_TX_LIN_CHANNELS = 19;

  // Depth of the outstanding-read ID FIFO.
  localparam int UDMA_ARB_MAX_OUTST = 4;

  // Channel index as carried through the ID FIFO.
  typedef logic [$clog2(N_TX_LIN_CHANNELS)-1:0] ch_id_t;

  // IDLE: no request on the L2 port.
  // WAIT_GNT: a winner is locked and l2 req is held until granted.
  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT_GNT
  } arb_state_e;

endpackage

// File: rtl/udma_lin_tx_arbiter_if.sv
// L2 read-port bundle between the TX arbiter and the uDMA L2 interconnect.
// Signals:
//   req    - read request, held until gnt
//   addr   - read address, stable while req is high
//   gnt    - grant from the interconnect (handshake = req & gnt)
//   rvalid - read response valid, in order, one per granted request
//   rdata  - read response data
// Modports: master (arbiter side), slave (interconnect side).
interface udma_lin_tx_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/udma_lin_tx_arbiter_id_fifo.sv
// udma_arb_id_fifo: DEPTH-entry FIFO of channel IDs for outstanding L2 reads.
// Ports:
//   clk_i, rstn_i - clock, asynchronous active-low reset
//   push_i, id_i  - enqueue the ID of a granted read (ignored when full)
//   pop_i         - dequeue the head on a read response (ignored when empty)
//   id_o          - head entry (owner of the oldest outstanding read)
//   full_o, empty_o, count_o - occupancy status
module udma_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 5
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [ID_W-1:0]            id_i,
  input  logic                       pop_i,
  output logic [ID_W-1:0]            id_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign id_o    = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= id_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/udma_lin_tx_arbiter.sv
// udma_lin_tx_arbiter: round-robin arbiter sharing the uDMA L2 read port
// between all TX linear channels. One winner is locked per L2 transaction,
// outstanding reads are tracked in an ID FIFO and every response is routed
// back to the channel that issued it.
// Ports:
//   clk_i, rstn_i - clock, asynchronous active-low reset
//   ch_req_i      - per-channel read request
//   ch_addr_i     - per-channel read address
//   ch_gnt_o      - one-hot grant, same cycle as the L2 handshake
//   ch_rvalid_o   - one-hot registered response valid for the owning channel
//   ch_rdata_o    - registered response data, broadcast
//   l2            - L2 read port (master modport)
//   hiprio_i      - high-priority channel mask (only with UDMA_ARB_PRIO_EN)
//   err_o         - one-cycle pulse on a response with nothing outstanding
// Optional feature macro: UDMA_ARB_PRIO_EN (high-priority channels always
// beat normal channels; round-robin within each class).
module udma_lin_tx_arbiter
  import udma_lin_tx_arbiter_pkg::*;
#(
  parameter int N_CH      = N_TX_LIN_CHANNELS,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = UDMA_ARB_MAX_OUTST
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_CH-1:0]            ch_req_i,
  input  logic [N_CH-1:0][ADDR_W-1:0] ch_addr_i,
  output logic [N_CH-1:0]            ch_gnt_o,
  output logic [N_CH-1:0]            ch_rvalid_o,
  output logic [DATA_W-1:0]          ch_rdata_o,
  udma_lin_tx_arbiter_if.master      l2,
`ifdef UDMA_ARB_PRIO_EN
  input  logic [N_CH-1:0]            hiprio_i,
`endif
  output logic                       err_o
);

  localparam int ID_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(MAX_OUTST+1);

  arb_state_e        state_q;
  logic [ID_W-1:0]   owner_q;
  logic [ID_W-1:0]   ptr_q;
  logic              l2_req_q;
  logic [ADDR_W-1:0] l2_addr_q;

  logic [ID_W-1:0]   owner_inc;
  logic [N_CH-1:0]   owner_oh;
  logic              handshake;
  logic [N_CH-1:0]   arb_mask;
  logic [N_CH-1:0]   arb_mask_eff;
  logic [ID_W-1:0]   arb_start;
  logic [ID_W-1:0]   arb_sel;
  logic              arb_found;
  int                arb_idx;

  logic [ID_W-1:0]   fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop_ok;
  logic              slots_ok_hs;

  assign l2.req    = l2_req_q;
  assign l2.addr   = l2_addr_q;
  assign handshake = l2_req_q & l2.gnt;
  assign owner_oh  = N_CH'(1) << owner_q;
  assign owner_inc = (owner_q == ID_W'(N_CH-1)) ? '0 : owner_q + 1'b1;
  assign ch_gnt_o  = handshake ? owner_oh : '0;
  assign pop_ok    = l2.rvalid & ~fifo_empty;

  // Re-arbitrating in the handshake cycle must see the count after this
  // cycle's push: a same-cycle pop frees the slot the push takes.
  assign slots_ok_hs = pop_ok | (fifo_count < CNT_W'(MAX_OUTST-1));

  udma_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (handshake),
    .id_i    (owner_q),
    .pop_i   (l2.rvalid),
    .id_o    (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Round-robin select. In IDLE the search starts at the pointer; in the
  // handshake cycle it starts after the owner being granted and excludes
  // that owner, whose request is still high for the current transaction.
  always_comb begin
    arb_mask  = ch_req_i;
    arb_start = ptr_q;
    if (state_q == ARB_WAIT_GNT) begin
      arb_mask  = ch_req_i & ~owner_oh;
      arb_start = owner_inc;
    end
`ifdef UDMA_ARB_PRIO_EN
    arb_mask_eff = ((arb_mask & hiprio_i) != '0) ? (arb_mask & hiprio_i) : arb_mask;
`else
    arb_mask_eff = arb_mask;
`endif
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      arb_idx = int'(arb_start) + k;
      if (arb_idx >= N_CH) begin
        arb_idx = arb_idx - N_CH;
      end
      if (!arb_found && arb_mask_eff[ID_W'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_sel   = ID_W'(arb_idx);
      end
    end
  end

  // Arbitration FSM. Owner, address and request are registered so the L2
  // side sees them stable for the whole WAIT_GNT period.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      l2_req_q  <= 1'b0;
      l2_addr_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (arb_found && !fifo_full) begin
            owner_q   <= arb_sel;
            l2_addr_q <= ch_addr_i[arb_sel];
            l2_req_q  <= 1'b1;
            state_q   <= ARB_WAIT_GNT;
          end
        end
        ARB_WAIT_GNT: begin
          if (l2.gnt) begin
            ptr_q <= owner_inc;
            if (arb_found && slots_ok_hs) begin
              owner_q   <= arb_sel;
              l2_addr_q <= ch_addr_i[arb_sel];
            end else begin
              l2_req_q <= 1'b0;
              state_q  <= ARB_IDLE;
            end
          end
        end
        default: begin
          state_q  <= ARB_IDLE;
          l2_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Response register: route the popped head to its channel one cycle
  // after l2 rvalid, and flag responses that arrive with nothing pending.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_rvalid_o <= '0;
      ch_rdata_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      ch_rvalid_o <= '0;
      err_o       <= l2.rvalid & fifo_empty;
      if (pop_ok) begin
        ch_rvalid_o <= N_CH'(1) << fifo_head;
        ch_rdata_o  <= l2.rdata;
      end
    end
  end

endmodule

// File: tb/tb_udma_lin_tx_arbiter.sv
// Self-checking bench for udma_lin_tx_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a queue-based behavioural model of the arbiter.
// Honours UDMA_ARB_PRIO_EN when the design is built with it.
module tb_udma_lin_tx_arbiter;
  import udma_lin_tx_arbiter_pkg::*;

  localparam int N_CH      = 19;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_OUTST = 4;

  logic                        clk_i = 1'b0;
  logic                        rstn_i;
  logic [N_CH-1:0]             ch_req_i;
  logic [N_CH-1:0][ADDR_W-1:0] ch_addr_i;
  logic [N_CH-1:0]             ch_gnt_o;
  logic [N_CH-1:0]             ch_rvalid_o;
  logic [DATA_W-1:0]           ch_rdata_o;
  logic                        err_o;
`ifdef UDMA_ARB_PRIO_EN
  logic [N_CH-1:0]             hiprio_i;
`endif

  udma_lin_tx_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) l2_bus ();

  udma_lin_tx_arbiter #(
    .N_CH      (N_CH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .ch_req_i    (ch_req_i),
    .ch_addr_i   (ch_addr_i),
    .ch_gnt_o    (ch_gnt_o),
    .ch_rvalid_o (ch_rvalid_o),
    .ch_rdata_o  (ch_rdata_o),
    .l2          (l2_bus.master),
`ifdef UDMA_ARB_PRIO_EN
    .hiprio_i    (hiprio_i),
`endif
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Stimulus that will be applied on the next cycle.
  logic [N_CH-1:0]             drv_req;
  logic [N_CH-1:0][ADDR_W-1:0] drv_addr;
  logic                        drv_gnt;
  logic                        drv_rvalid;
  logic [DATA_W-1:0]           drv_rdata;
  logic [N_CH-1:0]             drv_hiprio;

  // Behavioural model: pending L2 request, pointer, queue of outstanding
  // owners and the registered response outputs.
  bit                m_req;
  int                m_owner;
  logic [ADDR_W-1:0] m_addr;
  int                m_ptr;
  int                m_q[$];
  logic [N_CH-1:0]   m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  bit                m_err;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int onehot_index(input logic [N_CH-1:0] v);
    int idx = -1;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) idx = (idx == -1) ? i : -2;
    end
    return idx;
  endfunction

  // First eligible channel at or after start, with high-priority requests
  // taking the whole decision when any are pending.
  function automatic int pick(input logic [N_CH-1:0] mask, input int start);
    logic [N_CH-1:0] m = mask;
`ifdef UDMA_ARB_PRIO_EN
    if ((mask & drv_hiprio) != '0) m = mask & drv_hiprio;
`endif
    for (int k = 0; k < N_CH; k++) begin
      if (m[(start + k) % N_CH]) return (start + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic apply_stimulus();
    @(posedge clk_i);
    #1;
    ch_req_i      = drv_req;
    ch_addr_i     = drv_addr;
    l2_bus.gnt    = drv_gnt;
    l2_bus.rvalid = drv_rvalid;
    l2_bus.rdata  = drv_rdata;
`ifdef UDMA_ARB_PRIO_EN
    hiprio_i      = drv_hiprio;
`endif
  endtask

  task automatic compare_model();
    logic [N_CH-1:0] exp_gnt = '0;
    if (m_req && drv_gnt) exp_gnt[m_owner] = 1'b1;
    check_output("l2_req", l2_bus.req, m_req);
    if (m_req) check_output("l2_addr", l2_bus.addr, m_addr);
    check_output("ch_gnt", ch_gnt_o, exp_gnt);
    check_output("ch_rvalid", ch_rvalid_o, m_rvalid);
    if (m_rvalid != '0) check_output("ch_rdata", ch_rdata_o, m_rdata);
    check_output("err", err_o, m_err);
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_step();
    int cnt0 = m_q.size();
    bit hs = m_req && drv_gnt;
    bit popped = 0;
    int w;
    m_rvalid = '0;
    m_err    = 0;
    if (drv_rvalid) begin
      if (m_q.size() > 0) begin
        m_rvalid[m_q.pop_front()] = 1'b1;
        m_rdata = drv_rdata;
        popped  = 1;
      end else begin
        m_err = 1;
      end
    end
    if (hs) begin
      m_q.push_back(m_owner);
      drv_req[m_owner] = 1'b0;
    end
    if (!m_req) begin
      w = pick(drv_req, m_ptr);
      if (w >= 0 && cnt0 < MAX_OUTST) begin
        m_req = 1; m_owner = w; m_addr = drv_addr[w];
      end
    end else if (hs) begin
      m_ptr = (m_owner + 1) % N_CH;
      w = pick(drv_req, m_ptr);
      if (w >= 0 && (cnt0 + 1 - int'(popped)) < MAX_OUTST) begin
        m_owner = w; m_addr = drv_addr[w];
      end else begin
        m_req = 0;
      end
    end
  endtask

  task automatic cycle();
    apply_stimulus();
    @(negedge clk_i);
    compare_model();
    model_step();
  endtask

  task automatic do_reset();
    drv_req = '0; drv_addr = '0; drv_gnt = 0; drv_rvalid = 0; drv_rdata = '0; drv_hiprio = '0;
    ch_req_i = '0; ch_addr_i = '0;
    l2_bus.gnt = 0; l2_bus.rvalid = 0; l2_bus.rdata = '0;
`ifdef UDMA_ARB_PRIO_EN
    hiprio_i = '0;
`endif
    rstn_i = 1'b1;
    #1;
    rstn_i = 1'b0;
    #2;
    check_output("rst_l2_req", l2_bus.req, 0);
    check_output("rst_l2_addr", l2_bus.addr, 0);
    check_output("rst_ch_gnt", ch_gnt_o, 0);
    check_output("rst_ch_rvalid", ch_rvalid_o, 0);
    check_output("rst_ch_rdata", ch_rdata_o, 0);
    check_output("rst_err", err_o, 0);
    m_req = 0; m_owner = 0; m_addr = '0; m_ptr = 0; m_q.delete();
    m_rvalid = '0; m_rdata = '0; m_err = 0;
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  // Grant everything and answer every outstanding read until idle.
  task automatic drain();
    for (int c = 0; c < 60 && (m_q.size() > 0 || m_req || drv_req != '0); c++) begin
      drv_gnt = 1; drv_rvalid = (m_q.size() > 0); drv_rdata = $urandom;
      cycle();
    end
    drv_rvalid = 0;
    cycle();
    check_output("drain_idle", l2_bus.req, 0);
  endtask

  initial begin
    int w;
    int gl[$];
    int rl[$];
    int ngnt;
    int exp_fair[6] = '{0, 5, 18, 0, 5, 18};
    int exp_resp[5] = '{1, 2, 3, 9, 12};
    int t4_ch[5]    = '{1, 2, 3, 9, 12};

    do_reset();

    // Single request with the grant tied high.
    drv_gnt = 1; drv_req[4] = 1; drv_addr[4] = 32'h1C00_0100;
    cycle();
    check_output("t1_latency", l2_bus.req, 0);
    cycle();
    check_output("t1_l2_req", l2_bus.req, 1);
    check_output("t1_l2_addr", l2_bus.addr, 32'h1C00_0100);
    check_output("t1_gnt", ch_gnt_o, 19'h00010);
    drv_rvalid = 1; drv_rdata = 32'hDEAD_BEEF;
    cycle();
    drv_rvalid = 0;
    cycle();
    check_output("t1_rvalid", ch_rvalid_o, 19'h00010);
    check_output("t1_rdata", ch_rdata_o, 32'hDEAD_BEEF);

    // Fairness between channels 0, 5 and 18 from a fresh pointer.
    do_reset();
    drv_gnt = 1;
    for (int c = 0; c < 40 && gl.size() < 7; c++) begin
      drv_req[0] = 1; drv_req[5] = 1; drv_req[18] = 1;
      drv_addr[0] = 32'h100; drv_addr[5] = 32'h514; drv_addr[18] = 32'h1848;
      drv_rvalid = (m_q.size() > 0); drv_rdata = $urandom;
      cycle();
      w = onehot_index(ch_gnt_o);
      if (w != -1) gl.push_back(w);
    end
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("t2_order%0d", i), (i < gl.size()) ? gl[i] : -1, exp_fair[i]);
    end
    drv_req = '0;
    drain();

    // Stall: channel 2 locked while the grant is withheld, channel 1 waits.
    do_reset();
    drv_gnt = 0; drv_req[2] = 1; drv_addr[2] = 32'h1C00_2000;
    cycle();
    drv_req[1] = 1; drv_addr[1] = 32'h1C00_1000;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check_output("t3_hold_addr", l2_bus.addr, 32'h1C00_2000);
      check_output("t3_hold_gnt", ch_gnt_o, 0);
    end
    drv_gnt = 1;
    cycle();
    check_output("t3_first", ch_gnt_o, 19'h00004);
    cycle();
    check_output("t3_second", ch_gnt_o, 19'h00002);
    drain();

    // Outstanding limit: five requesters, no responses.
    do_reset();
    drv_gnt = 1; ngnt = 0;
    foreach (t4_ch[i]) begin
      drv_req[t4_ch[i]] = 1; drv_addr[t4_ch[i]] = 32'h2000 + 32'(t4_ch[i] * 16);
    end
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (ch_gnt_o != '0) ngnt++;
    end
    check_output("t4_grants_at_limit", ngnt, 4);
    check_output("t4_req_low", l2_bus.req, 0);
    drv_rvalid = 1; drv_rdata = $urandom;
    for (int c = 0; c < 5; c++) begin
      cycle();
      drv_rvalid = 0;
      if (ch_gnt_o != '0) ngnt++;
      w = onehot_index(ch_rvalid_o);
      if (w != -1) rl.push_back(w);
    end
    check_output("t4_fifth_grant", ngnt, 5);
    for (int c = 0; c < 20 && rl.size() < 5; c++) begin
      drv_rvalid = (m_q.size() > 0); drv_rdata = $urandom;
      cycle();
      w = onehot_index(ch_rvalid_o);
      if (w != -1) rl.push_back(w);
    end
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("t4_resp%0d", i), (i < rl.size()) ? rl[i] : -1, exp_resp[i]);
    end
    drain();

    // Spurious response with nothing outstanding.
    drv_rvalid = 1; drv_rdata = 32'h5555_AAAA;
    cycle();
    drv_rvalid = 0;
    cycle();
    check_output("t5_err", err_o, 1);
    check_output("t5_no_rvalid", ch_rvalid_o, 0);
    cycle();
    check_output("t5_err_pulse", err_o, 0);

    // Reset with three reads outstanding; the late response is flagged.
    drv_gnt = 1;
    drv_req[6] = 1; drv_req[7] = 1; drv_req[8] = 1;
    for (int c = 0; c < 10 && m_q.size() < 3; c++) cycle();
    do_reset();
    drv_rvalid = 1; drv_rdata = 32'h1234_5678;
    cycle();
    drv_rvalid = 0;
    cycle();
    check_output("t5_inflight_err", err_o, 1);
    check_output("t5_inflight_rvalid", ch_rvalid_o, 0);

`ifdef UDMA_ARB_PRIO_EN
    // Channel 7 is high priority; after channel 18 the pointer sits at 0,
    // so plain round-robin would choose 3.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drv_hiprio = '0; drv_hiprio[7] = 1;
      drv_req[18] = 1; drv_addr[18] = 32'h18;
      drain();
      drv_req[3] = 1; drv_req[7] = 1; drv_addr[3] = 32'h30; drv_addr[7] = 32'h70;
      w = -1;
      for (int c = 0; c < 8 && w == -1; c++) begin
        drv_gnt = 1; drv_rvalid = 0;
        cycle();
        w = onehot_index(ch_gnt_o);
      end
      check_output($sformatf("t6_prio_round%0d", r), w, 7);
      drain();
    end
`endif

    // Randomized traffic against the model, with one reset in the middle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      for (int i = 0; i < N_CH; i++) begin
        if (!drv_req[i] && ($urandom % 8 == 0)) begin
          drv_req[i] = 1; drv_addr[i] = {$urandom} & 32'hFFFF_FFFC;
        end
      end
      drv_gnt    = ($urandom % 4 != 0);
      drv_rvalid = (m_q.size() > 0) ? ($urandom % 3 != 0) : ($urandom % 50 == 0);
      drv_rdata  = $urandom;
      if (c % 100 == 0) drv_hiprio = N_CH'($urandom) & N_CH'($urandom) & N_CH'($urandom);
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
